// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver
//
// Oversamples the serial line with the system clock. A falling edge on the
// idle-high line starts a frame. The start bit is confirmed at mid-bit, and
// each data bit and the stop bit are then sampled one bit period apart.
// A correctly framed byte is presented on output_stream and held there until
// the next good frame. A low stop bit raises frame_error. The receiver then
// waits for the line to return high, so a held-low line cannot produce a
// stream of frames.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per serial bit (must be >= 4)
//   DATA_BITS     data bits per frame, LSB first
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high reset
//   input_stream   in   serial line, idle high
//   output_stream  out  last correctly framed byte
//   data_valid     out  one-cycle pulse when output_stream is updated
//   frame_error    out  one-cycle pulse when the stop bit samples low
//   busy           out  high in every state except IDLE
//
// Build option:
//   RX_SYNC_EN  when defined, input_stream passes through a 2-flop
//               synchronizer (reset value 1) before use. Every sample point
//               and latency then moves 2 cycles later.
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 2605,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 input_stream,
    output logic [DATA_BITS-1:0] output_stream,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // The counter starts at 0 on the edge that leaves IDLE. The start-bit
    // check therefore fires on the edge where the counter would reach HALF,
    // which is HALF edges after the first low sample.
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       bit_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   out_q;
    logic                   data_valid_q;
    logic                   frame_error_q;
    logic                   rx;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;

    // Resetting the synchronizer to 1 (idle line) keeps a reset from
    // looking like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], input_stream};
        end
    end

    assign rx = sync_q[1];
`else
    assign rx = input_stream;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the whole datapath, shift register included, is reset so that
            // an aborted frame cannot leak partial data into a later byte.
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            out_q         <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout. Every branch below
            // reads the pre-edge value of each register.
            // The pulse outputs default low and are raised for a single cycle.
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx) begin
                        state_q <= START;
                    end
                end

                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        // The line is high again at mid-start-bit, so this was a glitch.
                        state_q   <= rx ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rx;
                        if (bit_idx_q == LAST_IDX) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        // Leaving at mid-stop-bit lets a start bit that follows
                        // immediately be caught with no idle gap.
                        if (rx) begin
                            out_q        <= shift_q;
                            data_valid_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            frame_error_q <= 1'b1;
                            state_q       <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                BREAK: begin
                    if (rx) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign output_stream = out_q;
    assign data_valid    = data_valid_q;
    assign frame_error   = frame_error_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx
//
// CLKS_PER_BIT is reduced to 16 to keep the run short. Expected values are
// the hand-computed bytes and the latency formula
//   HALF + (DATA_BITS+1)*CLKS_PER_BIT (+2 when RX_SYNC_EN is defined).
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
`ifdef RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int LAT = HALF + 9 * CPB + SYNC_LAT;

    logic       clock = 1'b0;
    logic       reset;
    logic       input_stream;
    logic [7:0] output_stream;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    int cyc        = 0;
    int dv_count   = 0;
    int fe_count   = 0;
    int dv_cyc     = 0;
    int last_start = 0;
    int n_tests    = 0;
    int n_fail     = 0;
    int dv0;
    int fe0;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .input_stream (input_stream),
        .output_stream(output_stream),
        .data_valid   (data_valid),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    // Counts edges and logs output pulses, sampled 1 time unit after each edge.
    always @(posedge clock) begin
        #1;
        cyc = cyc + 1;
        if (data_valid) begin
            dv_count = dv_count + 1;
            dv_cyc   = cyc;
        end
        if (frame_error) begin
            fe_count = fe_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Call at a falling edge. Drives start, 8 data bits LSB first, then the stop bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        logic [9:0] bits;
        bits       = {stop_bit, data, 1'b0};
        last_start = cyc;
        for (int i = 0; i < 10; i++) begin
            input_stream = bits[i];
            repeat (CPB) @(negedge clock);
        end
    endtask

    initial begin
        input_stream = 1'b1;
        reset        = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_out",  32'(output_stream), 32'h00);
        check("rst_dv",   32'(data_valid),    32'd0);
        check("rst_fe",   32'(frame_error),   32'd0);
        check("rst_busy", 32'(busy),          32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Good frame 0x93: check the byte, a single pulse and the exact latency.
        dv0 = dv_count;
        fe0 = fe_count;
        send_frame(8'h93, 1'b1);
        check("f93_out",  32'(output_stream),       32'h93);
        check("f93_dv",   32'(dv_count - dv0),      32'd1);
        check("f93_lat",  32'(dv_cyc - last_start), 32'(LAT + 1));
        check("f93_fe",   32'(fe_count - fe0),      32'd0);
        check("f93_busy", 32'(busy),                32'd0);

        // Short low glitch is rejected at mid-start-bit.
        dv0 = dv_count;
        input_stream = 1'b0;
        repeat (4) @(negedge clock);
        check("gl_busy_hi", 32'(busy), 32'd1);
        input_stream = 1'b1;
        repeat (HALF + 1 - 4 + SYNC_LAT) @(negedge clock);
        check("gl_busy_lo", 32'(busy),           32'd0);
        check("gl_out",     32'(output_stream),  32'h93);
        check("gl_dv",      32'(dv_count - dv0), 32'd0);
        repeat (4) @(negedge clock);

        // Frame 0x5A with a low stop bit, then the line is held low as a break.
        dv0 = dv_count;
        fe0 = fe_count;
        send_frame(8'h5A, 1'b0);
        check("fe_pulse", 32'(fe_count - fe0),  32'd1);
        check("fe_dv",    32'(dv_count - dv0),  32'd0);
        check("fe_out",   32'(output_stream),   32'h93);
        repeat (3 * CPB) @(negedge clock);
        check("brk_busy", 32'(busy),            32'd1);
        check("brk_fe",   32'(fe_count - fe0),  32'd1);
        input_stream = 1'b1;
        repeat (4) @(negedge clock);
        check("brk_exit", 32'(busy),            32'd0);
        send_frame(8'h3C, 1'b1);
        check("f3c_out",  32'(output_stream),   32'h3C);
        check("f3c_dv",   32'(dv_count - dv0),  32'd1);

        // Back-to-back frames with no idle time between stop and start.
        dv0 = dv_count;
        send_frame(8'h55, 1'b1);
        check("b2b_first", 32'(output_stream),  32'h55);
        send_frame(8'hA3, 1'b1);
        check("b2b_out",   32'(output_stream),  32'hA3);
        check("b2b_dv",    32'(dv_count - dv0), 32'd2);

        // Reset pulse in the middle of the data bits of a 0xFF frame.
        input_stream = 1'b0;
        repeat (CPB) @(negedge clock);
        input_stream = 1'b1;
        repeat (2 * CPB + 3) @(negedge clock);
        check("mid_busy", 32'(busy), 32'd1);
        dv0   = dv_count;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mrst_out",  32'(output_stream), 32'h00);
        check("mrst_busy", 32'(busy),          32'd0);
        check("mrst_dv",   32'(data_valid),    32'd0);
        repeat (CPB) @(negedge clock);
        check("mrst_idle", 32'(busy),           32'd0);
        check("mrst_nodv", 32'(dv_count - dv0), 32'd0);
        send_frame(8'h81, 1'b1);
        check("f81_out",   32'(output_stream),  32'h81);
        check("f81_dv",    32'(dv_count - dv0), 32'd1);

        repeat (4) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
